wb_ifetch: RTL and testbench

Instruction prefetch master for the J1 core. It streams sequential 16-bit instruction words from the Wishbone ROM slave using classic pipelined read cycles and buffers them in a small FIFO. It presents them to the core through a valid/ready handshake. A core redirect (branch, call, return) flushes the buffer, discards in-flight acks and restarts fetching at the new address.

---
 rtl/wb_ifetch_pkg.sv | 19 +
 rtl/if_wb.sv | 18 +
 rtl/fifo_sync.sv | 69 ++++++
 rtl/wb_ifetch.sv | 134 +++++++++++++
 tb/tb_wb_ifetch.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ifetch_pkg.sv
// Shared types and default sizing for the J1 instruction prefetch master.
package wb_ifetch_pkg;

    localparam int IFETCH_DEPTH = 4;
    localparam int IFETCH_AW    = 13;
    localparam int IFETCH_DW    = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } ifetch_state_t;

    typedef struct packed {
        logic [IFETCH_AW-1:0] pc;
        logic [IFETCH_DW-1:0] insn;
    } ifetch_entry_t;

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone read-only bus between the prefetch master and the ROM.
interface if_wb #(
    parameter int AW = 13,
    parameter int DW = 16
) (
    input logic clk
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic          ack;
    logic          stall;
    logic [DW-1:0] dat_r;

    modport master (input clk, ack, stall, dat_r, output cyc, stb, adr, we);
    modport slave  (input clk, cyc, stb, adr, we, output ack, stall, dat_r);
endinterface

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered head, synchronous flush and occupancy count.
module fifo_sync
    import wb_ifetch_pkg::*;
#(
    parameter int WIDTH = $bits(ifetch_entry_t),
    parameter int DEPTH = IFETCH_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok, push_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_ifetch.sv
// J1 instruction prefetch master: pipelined Wishbone reads into a small FIFO.
// Optional WB_IFETCH_BYPASS_EN presents an ack straight to the core when the FIFO is empty.
module wb_ifetch
    import wb_ifetch_pkg::*;
#(
    parameter int          DEPTH    = IFETCH_DEPTH,
    parameter int          AW       = IFETCH_AW,
    parameter int          DW       = IFETCH_DW,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [DW-1:0] insn,
    output logic [AW-1:0] insn_pc,
    output logic          insn_valid,
    input  logic          insn_ready,
    if_wb.master          wb
);
    localparam int            CW     = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

    ifetch_state_t    state_q, state_d;
    logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]    push_pc_q, push_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    discard_q, discard_d;
    logic [CW-1:0]    count;
    logic [AW+DW-1:0] head;
    logic [CW:0]      inflight;
    logic             stb, accept, ack_ok, live_ack, push, pop;

    // Acks arriving with nothing outstanding (e.g. just after reset) are ignored.
    always_comb begin
        inflight      = (CW+1)'(outstanding_q) + (CW+1)'(count);
        stb           = (state_q == FETCH) && (inflight < (CW+1)'(DEPTH));
        accept        = stb && !wb.stall;
        ack_ok        = wb.ack && (outstanding_q != '0);
        live_ack      = ack_ok && (discard_q == '0) && !redirect;
        outstanding_d = outstanding_q + CW'(accept) - CW'(ack_ok);
    end

`ifdef WB_IFETCH_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass     = live_ack && (count == '0);
        insn_valid = (count != '0) || bypass;
        insn_pc    = '0;
        insn       = '0;
        if (count != '0) begin
            {insn_pc, insn} = head;
        end else if (bypass) begin
            insn_pc = push_pc_q;
            insn    = wb.dat_r;
        end
        push = live_ack && !(bypass && insn_ready);
        pop  = (count != '0) && insn_ready;
    end
`else
    always_comb begin
        insn_valid      = (count != '0);
        {insn_pc, insn} = insn_valid ? head : '0;
        push            = live_ack;
        pop             = insn_valid && insn_ready;
    end
`endif

    // A redirect's discard count includes a request accepted in that same cycle.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_pc_d  = push_pc_q;
        discard_d  = discard_q;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
        if (live_ack) begin
            push_pc_d = push_pc_q + 1'b1;
        end
        if (ack_ok && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   state_d = (discard_d == '0) ? FETCH : DRAIN;
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            push_pc_d  = redirect_pc;
            discard_d  = outstanding_d;
            state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= PC_RST;
            push_pc_q     <= PC_RST;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            push_pc_q     <= push_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign wb.cyc = stb || (outstanding_q != '0);
    assign wb.stb = stb;
    assign wb.adr = fetch_pc_q;
    assign wb.we  = 1'b0;

    fifo_sync #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wdata ({push_pc_q, wb.dat_r}),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

endmodule

// File: tb/tb_wb_ifetch.sv
// Randomised bench for wb_ifetch: ROM / zero-stall / random Wishbone slave plus a stream model.
module tb_wb_ifetch;
    localparam int            DEPTH = 4;
    localparam int            AW    = 13;
    localparam int            DW    = 16;
    localparam logic [AW-1:0] RPC   = '0;
`ifdef WB_IFETCH_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          insn_ready = 1'b0;
    logic [DW-1:0] insn;
    logic [AW-1:0] insn_pc;
    logic          insn_valid;

    always #5 clk = ~clk;

    if_wb #(.AW(AW), .DW(DW)) bus (.clk(clk));

    wb_ifetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .wb          (bus)
    );

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return DW'(a) ^ 16'hA5A5;
    endfunction

    // Slave: mode 0 = ROM (stall until ack), 1 = zero-stall, 2 = random stall/latency
    int            mode = 0;
    logic          ack_r = 1'b0;
    logic          stall_r = 1'b0;
    logic [DW-1:0] dat_r = '0;
    logic [DW-1:0] pq[$];
    logic          acc;

    assign bus.ack   = ack_r;
    assign bus.dat_r = dat_r;
    assign bus.stall = (mode == 0) ? ack_r : ((mode == 1) ? 1'b0 : stall_r);
    assign acc       = bus.cyc & bus.stb & ~bus.stall;

    always @(posedge clk) begin
        if (mode == 2) begin
            if (!rst_n) begin
                pq.delete();
                ack_r   <= 1'b0;
                stall_r <= 1'b0;
            end else begin
                if (ack_r) void'(pq.pop_front());
                if (acc) pq.push_back(rom_word(bus.adr));
                if (pq.size() > 0 && $urandom_range(3) != 0) begin
                    ack_r <= 1'b1;
                    dat_r <= pq[0];
                end else begin
                    ack_r <= 1'b0;
                end
                stall_r <= ($urandom_range(2) == 0);
            end
        end else begin
            ack_r   <= acc;
            dat_r   <= rom_word(bus.adr);
            stall_r <= 1'b0;
        end
    end

    // Requests accepted on the bus and not yet answered
    int outs;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) outs <= 0;
        else outs <= outs + int'(acc) - int'(ack_r && outs > 0);
    end

    // Stream model: after reset/redirect the core must see mem[X], mem[X+1], ... in order.
    logic [AW-1:0] exp_pc = RPC;
    logic          hold = 1'b0;
    logic [DW-1:0] h_insn;
    logic [AW-1:0] h_pc;
    logic [AW-1:0] got_pc[$];
    logic [DW-1:0] got_insn[$];
    int            hs_cnt = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_pc <= RPC;
            hold   <= 1'b0;
            if (!clk) begin
                chk("rst_cyc", bus.cyc, 0);
                chk("rst_stb", bus.stb, 0);
                chk("rst_we", bus.we, 0);
                chk("rst_adr", bus.adr, RPC);
                chk("rst_valid", insn_valid, 0);
                chk("rst_insn", insn, 0);
                chk("rst_pc", insn_pc, 0);
            end
        end else begin
            if (hold) begin
                chk("hold_valid", insn_valid, 1);
                chk("hold_insn", insn, h_insn);
                chk("hold_pc", insn_pc, h_pc);
            end
            chk("we_low", bus.we, 0);
            chk("outs_cap", outs <= DEPTH, 1);
            if (insn_valid && insn_ready) begin
                chk("stream_pc", insn_pc, exp_pc);
                chk("stream_insn", insn, rom_word(exp_pc));
                got_pc.push_back(insn_pc);
                got_insn.push_back(insn);
                hs_cnt <= hs_cnt + 1;
            end
            if (redirect) exp_pc <= redirect_pc;
            else if (insn_valid && insn_ready) exp_pc <= exp_pc + 1'b1;
            hold   <= insn_valid && !insn_ready && !redirect;
            h_insn <= insn;
            h_pc   <= insn_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int m);
        rst_n    = 1'b0;
        redirect = 1'b0;
        repeat (3) tick();
        mode = m;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k = 0;
        while (got_pc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, got_pc.size() >= n, 1);
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        int k;
        logic [AW-1:0] h;
        logic [AW-1:0] wrap_exp[4];

        // Reset state, then first word latency with the ROM
        repeat (3) tick();
        insn_ready = 1'b1;
        do_reset(0);
        n = 0;
        @(negedge clk);
        while (!insn_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_cycle", n, LAT);
        chk("first_pc", insn_pc, 13'h0000);
        chk("first_insn", insn, 16'hA5A5);
        tick();
        c0 = hs_cnt;
        repeat (20) tick();
        chk("rom_rate_ok", (hs_cnt - c0 >= 9) && (hs_cnt - c0 <= 11), 1);

        // Core stalls: FIFO fills, bus released, then back-to-back drain
        insn_ready = 1'b0;
        do_reset(0);
        repeat (20) tick();
        chk("fill_cyc", bus.cyc, 0);
        chk("fill_stb", bus.stb, 0);
        chk("fill_outs", outs, 0);
        chk("fill_valid", insn_valid, 1);
        got_pc.delete();
        got_insn.delete();
        insn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", insn_valid, 1);
            chk("drain_pc", insn_pc, i);
        end
        tick();
        wait_got(5, 20, "resume_seen");
        if (got_pc.size() >= 5) chk("resume_pc", got_pc[4], 13'h0004);

        // Redirect while a request is outstanding (its ack lands in the redirect cycle)
        k = 0;
        while (outs != 1 && k < 20) begin
            tick();
            k++;
        end
        chk("outs_one_found", outs, 1);
        got_pc.delete();
        got_insn.delete();
        insn_ready = 1'b0;
        pulse_redirect(13'h0100);
        insn_ready = 1'b1;
        wait_got(2, 30, "redir100_seen");
        if (got_pc.size() >= 2) begin
            chk("redir100_pc", got_pc[0], 13'h0100);
            chk("redir100_insn", got_insn[0], 16'hA4A5);
            chk("redir100_next", got_pc[1], 13'h0101);
        end

        // Address wrap
        wrap_exp = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
        got_pc.delete();
        got_insn.delete();
        insn_ready = 1'b0;
        pulse_redirect(13'h1FFE);
        insn_ready = 1'b1;
        wait_got(4, 40, "wrap_seen");
        if (got_pc.size() >= 4)
            for (int i = 0; i < 4; i++) chk("wrap_pc", got_pc[i], wrap_exp[i]);

        // Reset pulse while draining a stale request
        k = 0;
        while (!(bus.stb && !bus.stall) && k < 20) begin
            tick();
            k++;
        end
        chk("accept_found", bus.stb && !bus.stall, 1);
        pulse_redirect(13'h0800);
        chk("drain_outs", outs, 1);
        chk("drain_cyc", bus.cyc, 1);
        chk("drain_stb", bus.stb, 0);
        got_pc.delete();
        got_insn.delete();
        #1 rst_n = 1'b0;
        #1;
        chk("async_cyc", bus.cyc, 0);
        chk("async_stb", bus.stb, 0);
        chk("async_valid", insn_valid, 0);
        chk("async_insn", insn, 0);
        chk("async_pc", insn_pc, 0);
        chk("async_adr", bus.adr, RPC);
        #1 rst_n = 1'b1;
        wait_got(1, 20, "restart_seen");
        if (got_pc.size() >= 1) begin
            chk("restart_pc", got_pc[0], 13'h0000);
            chk("restart_insn", got_insn[0], 16'hA5A5);
        end

        // Redirect in the same cycle as a pop
        k = 0;
        while (!insn_valid && k < 20) begin
            tick();
            k++;
        end
        chk("valid_found", insn_valid, 1);
        h = insn_pc;
        got_pc.delete();
        got_insn.delete();
        pulse_redirect(13'h0555);
        wait_got(2, 30, "redirpop_seen");
        if (got_pc.size() >= 2) begin
            chk("redirpop_old", got_pc[0], h);
            chk("redirpop_new", got_pc[1], 13'h0555);
            chk("redirpop_insn", got_insn[1], 16'hA0F0);
        end

        // Zero-stall slave sustains one word per cycle
        do_reset(1);
        repeat (10) tick();
        c0 = hs_cnt;
        repeat (40) tick();
        chk("fast_rate_ok", hs_cnt - c0 >= 38, 1);

        // Random slave timing, core readiness and redirects
        do_reset(2);
        c0 = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            insn_ready = ($urandom_range(3) != 0);
            if ($urandom_range(40) == 0) begin
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(3) == 0) ? AW'(13'h1FFC + $urandom_range(3))
                                                       : AW'($urandom);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect = 1'b0;
        chk("random_progress", hs_cnt - c0 > 200, 1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
